jk_cmd_sequencer: RTL and testbench



---
 rtl/jk_pkg.sv | 34 +++
 rtl/jk_cmd_sequencer_if.sv | 25 ++
 rtl/jk_cmd_fifo.sv | 66 ++++++
 rtl/jk_cmd_sequencer.sv | 142 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the jk_flipflop command sequencer.
//
// Contents:
//   JK_HOLD/JK_CLR/JK_SET/JK_TGL  2-bit command opcodes. The opcode bits are
//                                 the J/K pair driven into the flip-flop.
//   ST_IDLE/ST_RUN                sequencer FSM state encodings.
//   cmd_w(cnt_w)                  FIFO word width: opcode plus repeat count.
//   jk_next(q, j, k)              next Q of a JK flip-flop.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int cmd_w(input int cnt_w);
        return 2 + cnt_w;
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// jk_cmd_sequencer_if: command handshake bundle for jk_cmd_sequencer.
//
// Handshake: a command {cmd_op, cmd_cnt} transfers at a rising clk edge where
// cmd_valid and cmd_ready are both high. The master holds cmd_op/cmd_cnt
// stable while cmd_valid is high and not yet accepted. cmd_ready depends only
// on the receiver's FIFO state, never on cmd_valid.
//
// Signals:
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  command FIFO not full
//   cmd_op     master->slave  00 hold, 01 clear, 10 set, 11 toggle
//   cmd_cnt    master->slave  repeat count (op lasts cmd_cnt+1 cycles)
//
// Modports: master (command source), slave (sequencer).
interface jk_cmd_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous FIFO with asynchronous active-high reset.
//
// Parameters:
//   WIDTH  word width
//   DEPTH  number of entries; power of two, at least 2
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset (empties FIFO)
//   push, wr_data    write request and data; ignored while full
//   pop              read request; ignored while empty
//   rd_data          head entry (valid while !empty)
//   full, empty      occupancy flags
//
// Pointers carry one extra bit so full and empty are distinguishable when
// the index bits match. A word written at an edge becomes visible at the
// head only after that edge, so an empty FIFO cannot pop what it is pushed.
module jk_cmd_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the natural pointer rollover is the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffered command stage driving a jk_flipflop.
//
// Commands (hold/clear/set/toggle with a repeat count) are queued in a FIFO
// and replayed as one registered J/K pair per clock. Each command drives its
// J/K for cnt+1 consecutive cycles; queued commands follow back-to-back.
// q_model tracks the flip-flop's Q cycle-accurately.
//
// Optional checker (macro JK_SEQ_CHECK_EN): compares q_in against q_model
// every edge and latches any mismatch into the sticky err flag. Without the
// macro err is constant 0 and q_in/err_clr are unused.
//
// Parameters:
//   DEPTH  command FIFO entries (power of two, >= 2)
//   CNT_W  repeat-count width
//
// Ports:
//   clk, reset  clock; asynchronous active-high reset clearing all state
//   cmd         command handshake (slave side of jk_cmd_sequencer_if)
//   J, K        registered J/K to the flip-flop
//   busy        running a command or commands queued
//   q_model     predicted flip-flop Q
//   q_in        actual flip-flop Q (checker only)
//   err         sticky mismatch flag (checker only)
//   err_clr     synchronous clear of err; a same-cycle mismatch wins
//   dbg_state   current FSM state (ST_IDLE / ST_RUN)
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    jk_cmd_sequencer_if.slave   cmd,
    output logic                J,
    output logic                K,
    output logic                busy,
    output logic                q_model,
    input  logic                q_in,
    output logic                err,
    input  logic                err_clr,
    output logic [0:0]          dbg_state
);
    localparam int CW = cmd_w(CNT_W);

    logic [0:0]       state;
    logic [CNT_W-1:0] remaining;
    logic [CW-1:0]    fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    // A pop happens whenever the current command has used its last cycle
    // (or none is running) and something is queued.
    assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || (remaining == '0));

    jk_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd.cmd_valid),
        .wr_data ({cmd.cmd_op, cmd.cmd_cnt}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full;
    assign busy          = (state == ST_RUN) || !fifo_empty;
    assign dbg_state     = state;

    // The opcode bits are the J/K pair directly: hold=00, clear=01, set=10,
    // toggle=11. remaining counts the cycles left after the current one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            J         <= 1'b0;
            K         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {J, K}    <= fifo_rd[CW-1 -: 2];
                        remaining <= fifo_rd[CNT_W-1:0];
                        state     <= ST_RUN;
                    end else begin
                        J <= 1'b0;
                        K <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                    end else if (!fifo_empty) begin
                        {J, K}    <= fifo_rd[CW-1 -: 2];
                        remaining <= fifo_rd[CNT_W-1:0];
                    end else begin
                        J     <= 1'b0;
                        K     <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    J         <= 1'b0;
                    K         <= 1'b0;
                end
            endcase
        end
    end

    // Shares reset with the flip-flop (Q=0) and sees the same J/K each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_model <= 1'b0;
        end else begin
            q_model <= jk_next(q_model, J, K);
        end
    end

`ifdef JK_SEQ_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (q_in != q_model) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = q_in ^ err_clr;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: self-checking bench for jk_cmd_sequencer.
//
// The reference model is a schedule: every accepted command is given a start
// cycle (one edge after acceptance, or right after the previous command ends,
// whichever is later) and runs for cnt+1 cycles. Per-cycle expected J/K
// values are queued in exp_q; FIFO occupancy, busy and ready follow from the
// schedule; Q follows the JK flip-flop rules. q_in is driven from the model's
// Q with an optional injected error. Honours JK_SEQ_CHECK_EN for err.
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int EW    = 34;   // {cycle[31:0], jk[1:0]}

`ifdef JK_SEQ_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        int acc;
        int start;
        int fin;
    } cmd_rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       q_in;
    logic       err_clr;
    logic       J;
    logic       K;
    logic       busy;
    logic       q_model;
    logic       err;
    logic [0:0] dbg_state;

    jk_cmd_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .q_model   (q_model),
        .q_in      (q_in),
        .err       (err),
        .err_clr   (err_clr),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc;   // number of rising edges since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    cmd_rec_t      cmds[$];
    int            prev_end;
    int            checks;
    int            failures;
    bit            inject;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic ff_rule(input logic q, input logic [1:0] jk);
        case (jk)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // ---------------- driver tasks (call at a negedge) ----------------
    task automatic send(input logic [1:0] op, input int cnt);
        int       guard;
        int       s;
        cmd_rec_t r;
        guard = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_cnt   = cnt[CNT_W-1:0];
        while (cmd_if.cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout cyc=%0d actual=ready_low expected=accept", cyc);
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        // Accepted at the coming edge, cyc+1.
        s = (cyc + 2 > prev_end + 1) ? cyc + 2 : prev_end + 1;
        r.acc   = cyc + 1;
        r.start = s;
        r.fin   = s + cnt;
        cmds.push_back(r);
        for (int i = 0; i <= cnt; i++) exp_q.push_back({32'(s + i), op});
        prev_end = s + cnt;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout cyc=%0d actual=busy expected=idle", cyc);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset_midrun();
        #2 reset = 1'b1;
        #1;
        check("rst_jk",      {J, K},        2'b00);
        check("rst_q_model", q_model,       1'b0);
        check("rst_ready",   cmd_if.cmd_ready, 1'b1);
        check("rst_busy",    busy,          1'b0);
        check("rst_state",   dbg_state,     1'b0);
        check("rst_err",     err,           1'b0);
        exp_q.delete();
        cmds.delete();
        prev_end = 0;
        q_in     = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic          q_e;
        logic          err_e;
        logic          mism_c;
        logic          clr_c;
        logic [1:0]    jk_prev;
        logic [1:0]    jk_e;
        logic [EW-1:0] e;
        int            occ;
        bit            act;
        q_e = 1'b0; err_e = 1'b0; jk_prev = 2'b00;
        forever begin
            @(posedge clk);
            mism_c = (q_in !== q_e);
            clr_c  = err_clr;
            @(negedge clk);
            if (reset) begin
                q_e = 1'b0; err_e = 1'b0; jk_prev = 2'b00;
                continue;
            end
            q_e  = ff_rule(q_e, jk_prev);
            jk_e = 2'b00;
            if (exp_q.size() > 0 && exp_q[0][EW-1:2] == 32'(cyc)) begin
                e    = exp_q.pop_front();
                jk_e = e[1:0];
            end
            if (CHK_EN && mism_c)     err_e = 1'b1;
            else if (CHK_EN && clr_c) err_e = 1'b0;
            while (cmds.size() > 0 && cmds[0].fin < cyc) void'(cmds.pop_front());
            occ = 0;
            act = 1'b0;
            for (int i = 0; i < cmds.size(); i++) begin
                if (cmds[i].acc <= cyc && cmds[i].start > cyc) occ++;
                if (cmds[i].start <= cyc && cmds[i].fin >= cyc) act = 1'b1;
            end
            check("jk",      {J, K},            jk_e);
            check("q_model", q_model,           q_e);
            check("busy",    busy,              act || occ > 0);
            check("ready",   cmd_if.cmd_ready,  occ < DEPTH);
            check("state",   dbg_state,         act);
            check("err",     err,               err_e);
            jk_prev = jk_e;
            #1 q_in = q_e ^ inject;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; q_in = 1'b0; err_clr = 1'b0; inject = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'b00; cmd_if.cmd_cnt = '0;
        prev_end = 0; checks = 0; failures = 0;
        #12 reset = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);            // idle after reset

        send(2'b10, 0);                         // set x1
        send(2'b11, 2);                         // toggle x3 back-to-back
        wait_idle();

        send(2'b11, 3); send(2'b10, 3); send(2'b11, 3);
        send(2'b01, 3); send(2'b11, 3);         // 5 commands into a 4-deep FIFO
        wait_idle();

        send(2'b10, 0);                         // set, then clear x16
        send(2'b01, 15);
        wait_idle();

        send(2'b11, 15);                        // maximum count toggle
        wait_idle();

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end
        wait_idle();

        send(2'b10, 1);                         // Q=1, then checker stimulus
        wait_idle();
        inject = 1'b1; @(negedge clk); inject = 1'b0;
        repeat (3) @(negedge clk);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        repeat (2) @(negedge clk);
        inject = 1'b1; err_clr = 1'b1; @(negedge clk);
        inject = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        repeat (2) @(negedge clk);

        send(2'b11, 15);                        // reset during a long toggle
        send(2'b10, 2);                         // queued, must never issue
        repeat (5) @(negedge clk);
        apply_reset_midrun();
        repeat (30) @(negedge clk);

        send(2'b10, 2);                         // normal operation after reset
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
